video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//   Raster timing source for the HDMI/VGA display path. Free-running H/V counters produce the
//   x, y, vde, hsync and vsync that the pixel generator consumes, plus line/frame strobes.
//   Sits between the pixel-clock domain root and the pixel generator/TMDS encoder. Default
//   timing is 1080p60 (2200 x 1125 total).
// PARAMETERS
//   WIDTH        1920  active pixels per line
//   HEIGHT       1080  active lines per frame
//   H_SYNC_TIME  44    hsync width, pixels
//   H_B_PORCH    148   horizontal back porch, pixels
//   H_F_PORCH    88    horizontal front porch, pixels
//   V_SYNC_TIME  5     vsync width, lines
//   V_B_PORCH    36    vertical back porch, lines
//   V_F_PORCH    4     vertical front porch, lines
//   SYNC_POL     1     active level of hsync/vsync (1 = active-high)
// PORTS
//   clk          in   1   pixel clock
//   rst_n        in   1   asynchronous reset, active-low
//   ce           in   1   pixel advance enable; counters step only when 1
//   x            out  16  raw horizontal count, 0..H_TOTAL-1
//   y            out  16  raw vertical count, 0..V_TOTAL-1
//   vde          out  1   1 when (x,y) is inside the active window
//   hsync        out  1   horizontal sync at SYNC_POL level
//   vsync        out  1   vertical sync at SYNC_POL level
//   line_start   out  1   one-clk pulse: counters just wrapped x to 0
//   frame_start  out  1   one-clk pulse: counters just wrapped to (0,0)
// BEHAVIOUR
// - H_TOTAL = H_SYNC_TIME+H_B_PORCH+WIDTH+H_F_PORCH; V_TOTAL analogous. Line order:
//   sync, back porch, active, front porch. Frame order is the same.
// - All outputs are registered and mutually aligned: each flag describes the (x,y) on the
//   same cycle. Flags are computed from next-count values, so there is zero skew to x/y.
// - hsync = SYNC_POL for x < H_SYNC_TIME, otherwise ~SYNC_POL. vsync is analogous on y.
// - vde = 1 when H_SYNC_TIME+H_B_PORCH <= x < H_SYNC_TIME+H_B_PORCH+WIDTH and the same
//   inequality holds for y with the V parameters.
// - ce=1: x <= x+1. When x == H_TOTAL-1: x <= 0 and y <= y+1. When y is also V_TOTAL-1,
//   y <= 0.
// - ce=0: every output holds, except line_start and frame_start, which drop to 0.
// - line_start = 1 for the single clk following a ce cycle with x == H_TOTAL-1.
// - frame_start additionally requires y == V_TOTAL-1 on that cycle; the two strobes
//   coincide on a frame wrap.
// - Reset (async assert, sync release), reset values:
//   x=0, y=0, hsync=SYNC_POL, vsync=SYNC_POL, vde=0, line_start=0, frame_start=0.
//   No strobe fires on reset release.
// - Reset mid-frame returns all outputs to the reset values immediately, independent of clk.
// - Counters are 16-bit. The implementation elaborates with $error if H_TOTAL or V_TOTAL
//   exceeds 65535.
// CONFIGURATION
//   VTG_FRAME_CNT_EN defined:
//     - Adds output port frame_cnt [15:0]: 0 on reset, +1 on every frame_start cycle.
//     - Wraps 0xFFFF -> 0x0000.
//   VTG_FRAME_CNT_EN undefined:
//     - The port does not exist. All other behaviour is identical.
// TESTING
//   1. Release reset, ce=1 held: x=0..43 -> hsync=1; x=44 -> hsync=0; x=2199 -> next x=0,
//      y=1, line_start=1 for one clk.
//   2. Active window: (191,41) -> vde=0; (192,41) -> vde=1; (2111,1120) -> vde=1;
//      (2112,1120) -> vde=0; y=1121 -> vde=0 for all x.
//   3. Frame wrap: (2199,1124) with ce=1 -> (0,0); frame_start=1 and line_start=1 for one clk;
//      vsync=1 for y=0..4, vsync=0 at y=5.
//   4. ce toggled 1,0,0,1 at x=2199: x holds at 2199 during ce=0, wraps on the next ce=1,
//      and each strobe fires exactly once.
//   5. Assert rst_n=0 at (1000,500) between clk edges: x, y, vde, hsync, vsync reach the
//      reset values before the next edge.
//   6. With VTG_FRAME_CNT_EN: run 3 frames -> frame_cnt=3. Force frame_cnt=0xFFFF, then one
//      frame wrap -> 0x0000.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running raster timing source (H/V counters, sync,
// data-enable and line/frame strobes). All outputs are registered and are
// derived from the next-count values, so every flag lines up with x/y.
// Optional feature: define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module video_timing_gen #(
    parameter int unsigned WIDTH       = 32'd1920,
    parameter int unsigned HEIGHT      = 32'd1080,
    parameter int unsigned H_SYNC_TIME = 32'd44,
    parameter int unsigned H_B_PORCH   = 32'd148,
    parameter int unsigned H_F_PORCH   = 32'd88,
    parameter int unsigned V_SYNC_TIME = 32'd5,
    parameter int unsigned V_B_PORCH   = 32'd36,
    parameter int unsigned V_F_PORCH   = 32'd4,
    parameter logic        SYNC_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        vde,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_SYNC_TIME + H_B_PORCH + WIDTH + H_F_PORCH;
    localparam int unsigned V_TOTAL = V_SYNC_TIME + V_B_PORCH + HEIGHT + V_F_PORCH;

    // Boundaries pre-cast to the 16-bit counter width.
    localparam logic [15:0] H_LAST      = 16'(H_TOTAL - 32'd1);
    localparam logic [15:0] V_LAST      = 16'(V_TOTAL - 32'd1);
    localparam logic [15:0] H_SYNC_END  = 16'(H_SYNC_TIME);
    localparam logic [15:0] V_SYNC_END  = 16'(V_SYNC_TIME);
    localparam logic [15:0] H_ACT_START = 16'(H_SYNC_TIME + H_B_PORCH);
    localparam logic [15:0] H_ACT_END   = 16'(H_SYNC_TIME + H_B_PORCH + WIDTH);
    localparam logic [15:0] V_ACT_START = 16'(V_SYNC_TIME + V_B_PORCH);
    localparam logic [15:0] V_ACT_END   = 16'(V_SYNC_TIME + V_B_PORCH + HEIGHT);

    // Totals beyond 16 bits cannot be represented by the counters.
    generate
        if (H_TOTAL > 32'd65535) begin : g_h_total_check
            $error("video_timing_gen: H_TOTAL exceeds 65535");
        end
        if (V_TOTAL > 32'd65535) begin : g_v_total_check
            $error("video_timing_gen: V_TOTAL exceeds 65535");
        end
    endgenerate

    logic [15:0] x_nxt_s;
    logic [15:0] y_nxt_s;
    logic        line_wrap_s;
    logic        frame_wrap_s;
    logic        hsync_nxt_s;
    logic        vsync_nxt_s;
    logic        vde_nxt_s;

    // Next raster position and wrap detection.
    always_comb begin
        x_nxt_s      = x;
        y_nxt_s      = y;
        line_wrap_s  = 1'b0;
        frame_wrap_s = 1'b0;
        if (ce) begin
            if (x == H_LAST) begin
                x_nxt_s     = 16'd0;
                line_wrap_s = 1'b1;
                if (y == V_LAST) begin
                    y_nxt_s      = 16'd0;
                    frame_wrap_s = 1'b1;
                end else begin
                    y_nxt_s = y + 16'd1;
                end
            end else begin
                x_nxt_s = x + 16'd1;
            end
        end else begin
            x_nxt_s = x;
        end
    end

    // Sync and data-enable decoded from the next position (zero skew to x/y).
    always_comb begin
        hsync_nxt_s = ~SYNC_POL;
        vsync_nxt_s = ~SYNC_POL;
        vde_nxt_s   = 1'b0;
        if (x_nxt_s < H_SYNC_END) begin
            hsync_nxt_s = SYNC_POL;
        end else begin
            hsync_nxt_s = ~SYNC_POL;
        end
        if (y_nxt_s < V_SYNC_END) begin
            vsync_nxt_s = SYNC_POL;
        end else begin
            vsync_nxt_s = ~SYNC_POL;
        end
        if ((x_nxt_s >= H_ACT_START) && (x_nxt_s < H_ACT_END) &&
            (y_nxt_s >= V_ACT_START) && (y_nxt_s < V_ACT_END)) begin
            vde_nxt_s = 1'b1;
        end else begin
            vde_nxt_s = 1'b0;
        end
    end

    // Output registers: counters, decoded flags and one-clock strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= 16'd0;
            y           <= 16'd0;
            vde         <= 1'b0;
            hsync       <= SYNC_POL;
            vsync       <= SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= x_nxt_s;
            y           <= y_nxt_s;
            vde         <= vde_nxt_s;
            hsync       <= hsync_nxt_s;
            vsync       <= vsync_nxt_s;
            line_start  <= line_wrap_s;
            frame_start <= frame_wrap_s;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    // Frame counter advances together with the frame_start strobe, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (frame_wrap_s) begin
            frame_cnt <= frame_cnt + 16'd1;
        end else begin
            frame_cnt <= frame_cnt;
        end
    end
`else
    // Frame counter not built in this configuration.
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed self-checking bench for video_timing_gen. One instance uses the
// default 1080p60 timing for line-level checks; a second, reduced-size instance
// (H_TOTAL=15, V_TOTAL=9) makes whole-frame checks cheap.
module tb_video_timing_gen;

    logic clk;
    logic rst_n;
    logic ce;

    logic [15:0] f_x, f_y, s_x, s_y;
    logic f_vde, f_hs, f_vs, f_ls, f_fs;
    logic s_vde, s_hs, s_vs, s_ls, s_fs;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] f_fc, s_fc;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Packed views: {x, y, vde, hsync, vsync, line_start, frame_start}
    logic [36:0] f_obs, s_obs;
    assign f_obs = {f_x, f_y, f_vde, f_hs, f_vs, f_ls, f_fs};
    assign s_obs = {s_x, s_y, s_vde, s_hs, s_vs, s_ls, s_fs};

    localparam logic [36:0] RST_OBS = {16'd0, 16'd0, 5'b01100};

    video_timing_gen dut_full (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .x(f_x), .y(f_y), .vde(f_vde), .hsync(f_hs), .vsync(f_vs),
        .line_start(f_ls), .frame_start(f_fs)
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(f_fc)
`endif
    );

    video_timing_gen #(
        .WIDTH(32'd8), .HEIGHT(32'd4),
        .H_SYNC_TIME(32'd2), .H_B_PORCH(32'd3), .H_F_PORCH(32'd2),
        .V_SYNC_TIME(32'd2), .V_B_PORCH(32'd2), .V_F_PORCH(32'd1),
        .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .x(s_x), .y(s_y), .vde(s_vde), .hsync(s_hs), .vsync(s_vs),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        ce = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ce = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (s_obs !== RST_OBS) $display("FAIL reset_small: got %h want %h", s_obs, RST_OBS);
        else pass_cnt++;
        total_cnt++;
        if (f_obs !== RST_OBS) $display("FAIL reset_full: got %h want %h", f_obs, RST_OBS);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (s_obs !== RST_OBS) $display("FAIL release_small: got %h want %h", s_obs, RST_OBS);
        else pass_cnt++;
        total_cnt++;
        if (f_obs !== RST_OBS) $display("FAIL release_full: got %h want %h", f_obs, RST_OBS);
        else pass_cnt++;
    endtask

    // First 1080p line: hsync for x<44, then wrap to (0,1) with line_start.
    task automatic test_line_full;
        logic [36:0] exp;
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 2200; i++) begin
            exp = {16'(i), 16'd0, 1'b0, 1'(i < 44), 1'b1, 1'b0, 1'b0};
            total_cnt++;
            if (f_obs !== exp) $display("FAIL line_full x=%0d: got %h want %h", i, f_obs, exp);
            else pass_cnt++;
            @(negedge clk);
        end
        exp = {16'd0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        total_cnt++;
        if (f_obs !== exp) $display("FAIL line_wrap_full: got %h want %h", f_obs, exp);
        else pass_cnt++;
        @(negedge clk);
        exp = {16'd1, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        total_cnt++;
        if (f_obs !== exp) $display("FAIL line_strobe_drop_full: got %h want %h", f_obs, exp);
        else pass_cnt++;
        ce = 1'b0;
    endtask

    // Whole small frame: active window x in [5,13), y in [4,8); syncs x<2, y<2.
    task automatic test_active_window;
        logic [36:0] exp;
        do_reset();
        ce = 1'b1;
        for (int ye = 0; ye < 9; ye++) begin
            for (int xe = 0; xe < 15; xe++) begin
                exp = {16'(xe), 16'(ye),
                       1'(xe >= 5 && xe < 13 && ye >= 4 && ye < 8),
                       1'(xe < 2), 1'(ye < 2),
                       1'(xe == 0 && ye != 0), 1'b0};
                total_cnt++;
                if (s_obs !== exp) $display("FAIL window (%0d,%0d): got %h want %h", xe, ye, s_obs, exp);
                else pass_cnt++;
                @(negedge clk);
            end
        end
    endtask

    // Continues from the end of test_active_window with ce still high.
    task automatic test_frame_wrap;
        logic [36:0] exp;
        exp = {16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        total_cnt++;
        if (s_obs !== exp) $display("FAIL frame_wrap: got %h want %h", s_obs, exp);
        else pass_cnt++;
        @(negedge clk);
        exp = {16'd1, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        total_cnt++;
        if (s_obs !== exp) $display("FAIL frame_strobe_drop: got %h want %h", s_obs, exp);
        else pass_cnt++;
        repeat (14) @(negedge clk);
        exp = {16'd0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        total_cnt++;
        if (s_obs !== exp) $display("FAIL vsync_last_line: got %h want %h", s_obs, exp);
        else pass_cnt++;
        repeat (15) @(negedge clk);
        exp = {16'd0, 16'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        total_cnt++;
        if (s_obs !== exp) $display("FAIL vsync_end: got %h want %h", s_obs, exp);
        else pass_cnt++;
        ce = 1'b0;
    endtask

    // ce pattern 1,0,0,1 at the last pixel of a line.
    task automatic test_ce_gap;
        logic [36:0] exp;
        do_reset();
        ce = 1'b1;
        repeat (14) @(negedge clk);
        exp = {16'd14, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        total_cnt++;
        if (s_obs !== exp) $display("FAIL ce_gap_arrive: got %h want %h", s_obs, exp);
        else pass_cnt++;
        ce = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total_cnt++;
            if (s_obs !== exp) $display("FAIL ce_gap_hold%0d: got %h want %h", k, s_obs, exp);
            else pass_cnt++;
        end
        ce = 1'b1;
        @(negedge clk);
        exp = {16'd0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        total_cnt++;
        if (s_obs !== exp) $display("FAIL ce_gap_wrap: got %h want %h", s_obs, exp);
        else pass_cnt++;
        ce = 1'b0;
        @(negedge clk);
        exp = {16'd0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        total_cnt++;
        if (s_obs !== exp) $display("FAIL ce_gap_strobe_drop: got %h want %h", s_obs, exp);
        else pass_cnt++;
    endtask

    // Reset asserted between clock edges while inside the active window.
    task automatic test_async_reset;
        logic [36:0] exp;
        do_reset();
        ce = 1'b1;
        repeat (82) @(negedge clk);
        exp = {16'd7, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (s_obs !== exp) $display("FAIL mid_frame: got %h want %h", s_obs, exp);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (s_obs !== RST_OBS) $display("FAIL async_reset_small: got %h want %h", s_obs, RST_OBS);
        else pass_cnt++;
        total_cnt++;
        if (f_obs !== RST_OBS) $display("FAIL async_reset_full: got %h want %h", f_obs, RST_OBS);
        else pass_cnt++;
        @(negedge clk);
        ce = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef VTG_FRAME_CNT_EN
    task automatic test_frame_cnt;
        do_reset();
        total_cnt++;
        if (s_fc !== 16'd0) $display("FAIL frame_cnt_reset: got %h want %h", s_fc, 16'd0);
        else pass_cnt++;
        ce = 1'b1;
        repeat (405) @(negedge clk);
        total_cnt++;
        if ({s_fc, s_fs} !== {16'd3, 1'b1}) $display("FAIL frame_cnt_3: got %h want %h", {s_fc, s_fs}, {16'd3, 1'b1});
        else pass_cnt++;
        ce = 1'b0;
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        ce = 1'b1;
        repeat (134) @(negedge clk);
        total_cnt++;
        if (s_fc !== 16'hFFFF) $display("FAIL frame_cnt_max: got %h want %h", s_fc, 16'hFFFF);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({s_fc, s_fs} !== {16'h0000, 1'b1}) $display("FAIL frame_cnt_wrap: got %h want %h", {s_fc, s_fs}, {16'h0000, 1'b1});
        else pass_cnt++;
        ce = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        ce = 1'b0;
        test_reset();
        test_line_full();
        test_active_window();
        test_frame_wrap();
        test_ce_gap();
        test_async_reset();
`ifdef VTG_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
